// File: rtl/rrp_arbiter_burst_pkg.sv
// Shared types and helpers for the round-robin-with-preemption burst arbiter.
package rrp_arbiter_burst_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Burst counter is wide enough for the largest supported MAX_BURST (255).
  localparam int unsigned BURST_CNT_W = 8;

  // Width of a channel index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/rrp_arbiter_burst_rr_select.sv
// Rotating-priority encoder: picks the first candidate strictly after last_i,
// wrapping N_CH-1 -> 0. Candidates are req_i qualified by hold_i, so the same
// block serves the hold-priority path (hold_i = HOLD_REQ, last_i = N_CH-1 gives
// lowest index first) and the plain round-robin path (hold_i = all ones).
module rrp_arbiter_burst_rr_select
  import rrp_arbiter_burst_pkg::*;
#(
  parameter  int unsigned N_CH  = 7,
  localparam int unsigned IDX_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [N_CH-1:0]  hold_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] sel_o,
  output logic             valid_o
);

  logic [N_CH-1:0] cand;

  assign cand = req_i & hold_i;

  // Scan N_CH positions starting one past last_i; the first hit wins.
  always_comb begin
    int unsigned idx;
    sel_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx = (32'(last_i) + k) % N_CH;
      if (!valid_o && cand[IDX_W'(idx)]) begin
        valid_o = 1'b1;
        sel_o   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rrp_arbiter_burst.sv
// Merges N_CH FWFT readout FIFOs into one registered word stream with
// round-robin fairness, a per-grant burst limit, sticky hold preemption and
// a per-channel enable mask.
module rrp_arbiter_burst
  import rrp_arbiter_burst_pkg::*;
#(
  parameter  int unsigned N_CH       = 7,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned MAX_BURST  = 16,
  localparam int unsigned IDX_W      = idx_width(N_CH)
) (
  input  logic                       CLK,
  input  logic                       RSTB,
  input  logic [N_CH-1:0]            EN_MASK,
  input  logic [N_CH-1:0]            WRITE_REQ,
  input  logic [N_CH-1:0]            HOLD_REQ,
  input  logic [N_CH*DATA_WIDTH-1:0] DATA_IN,
  output logic [N_CH-1:0]            READ_GRANT,
  input  logic                       READY_OUT,
  output logic                       WRITE_OUT,
  output logic [DATA_WIDTH-1:0]      DATA_OUT,
  output logic [IDX_W-1:0]           GRANT_IDX,
  output logic                       BUSY
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]       LAST_RST  = IDX_W'(N_CH - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   write_out_q, write_out_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;

  logic [N_CH-1:0]        elig;
  logic [N_CH-1:0]        grant_onehot;
  logic [DATA_WIDTH-1:0]  data_arr [N_CH];

  logic [IDX_W-1:0]       hold_idx, rr_idx;
  logic                   hold_valid, rr_valid;

  logic                   g_en, g_wr, g_hold;
  logic                   other_hold;
  logic                   pop_c;
  logic                   release_c;

  assign elig = EN_MASK & WRITE_REQ;

  // Unpack the flat head-word bus into one word per channel.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_unpack
    assign data_arr[i] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Hold path: fixed start at N_CH-1 so the lowest holding index wins.
  rrp_arbiter_burst_rr_select #(.N_CH(N_CH)) u_hold_sel (
    .req_i   (elig),
    .hold_i  (HOLD_REQ),
    .last_i  (LAST_RST),
    .sel_o   (hold_idx),
    .valid_o (hold_valid)
  );

  // Round-robin path: rotate from the last granted channel.
  rrp_arbiter_burst_rr_select #(.N_CH(N_CH)) u_rr_sel (
    .req_i   (elig),
    .hold_i  ({N_CH{1'b1}}),
    .last_i  (last_q),
    .sel_o   (rr_idx),
    .valid_o (rr_valid)
  );

  // Per-grant status of the currently granted channel.
  always_comb begin
    grant_onehot = '0;
    grant_onehot[grant_q] = 1'b1;
    g_en       = EN_MASK[grant_q];
    g_wr       = WRITE_REQ[grant_q];
    g_hold     = HOLD_REQ[grant_q];
    other_hold = |(elig & HOLD_REQ & ~grant_onehot);
    pop_c      = (state_q == ST_GRANT) && g_en && g_wr && READY_OUT;
    READ_GRANT = pop_c ? grant_onehot : '0;
  end

  // Next-state, selection, burst counting and output-stage inputs.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    release_c   = 1'b0;
    write_out_d = pop_c;
    data_out_d  = data_out_q;

    if (pop_c) begin
      data_out_d = data_arr[grant_q];
    end

    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          state_d     = ST_GRANT;
          grant_d     = hold_valid ? hold_idx : rr_idx;
          last_d      = hold_valid ? hold_idx : rr_idx;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // Counter freezes without a pop and saturates at the limit.
        if (pop_c && (burst_cnt_q < BURST_MAX)) begin
          burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
        end
        release_c = !g_en
                 || (!g_wr && !g_hold)
                 || (pop_c && (burst_cnt_d == BURST_MAX) && !g_hold)
                 || (!g_hold && other_hold);
        if (release_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and registered output stage.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= LAST_RST;
      burst_cnt_q <= '0;
      write_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      write_out_q <= write_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign WRITE_OUT = write_out_q;
  assign DATA_OUT  = data_out_q;
  assign GRANT_IDX = grant_q;
  assign BUSY      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rrp_arbiter_burst.sv
// Directed bench for rrp_arbiter_burst (4 channels, burst limit 2) with a
// simple counting FWFT source model per channel.
module tb_rrp_arbiter_burst;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            CLK;
  logic            RSTB;
  logic [N-1:0]    EN_MASK;
  logic [N-1:0]    WRITE_REQ;
  logic [N-1:0]    HOLD_REQ;
  logic [N*DW-1:0] DATA_IN;
  logic [N-1:0]    READ_GRANT;
  logic            READY_OUT;
  logic            WRITE_OUT;
  logic [DW-1:0]   DATA_OUT;
  logic [1:0]      GRANT_IDX;
  logic            BUSY;

  int rem [N];
  int cnt [N];
  int n_checks;
  int n_errors;

  rrp_arbiter_burst #(.N_CH(N), .DATA_WIDTH(DW), .MAX_BURST(2)) dut (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .EN_MASK    (EN_MASK),
    .WRITE_REQ  (WRITE_REQ),
    .HOLD_REQ   (HOLD_REQ),
    .DATA_IN    (DATA_IN),
    .READ_GRANT (READ_GRANT),
    .READY_OUT  (READY_OUT),
    .WRITE_OUT  (WRITE_OUT),
    .DATA_OUT   (DATA_OUT),
    .GRANT_IDX  (GRANT_IDX),
    .BUSY       (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Word n of channel i.
  function automatic logic [31:0] d(input int i, input int n);
    return 32'hA000_0000 | (32'(i) << 16) | 32'(n);
  endfunction

  task automatic upd();
    for (int i = 0; i < N; i++) begin
      WRITE_REQ[i] = (rem[i] > 0);
      DATA_IN[i*DW +: DW] = d(i, cnt[i]);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      cnt[i] = 0;
    end
    upd();
  endtask

  // One clock: note the pops, advance the sources after the edge, settle.
  task automatic cyc();
    logic [N-1:0] popped;
    #1;
    popped = READ_GRANT;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (popped[i]) begin
        cnt[i]++;
        if (rem[i] > 0) rem[i]--;
      end
    end
    upd();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] rg, input logic wo,
                         input logic [31:0] dout, input logic [1:0] gi, input logic b);
    chk({tag, ".read_grant"}, 32'(READ_GRANT), 32'(rg));
    chk({tag, ".write_out"},  32'(WRITE_OUT),  32'(wo));
    chk({tag, ".data_out"},   DATA_OUT,        dout);
    chk({tag, ".grant_idx"},  32'(GRANT_IDX),  32'(gi));
    chk({tag, ".busy"},       32'(BUSY),       32'(b));
  endtask

  initial begin
    int c, n, p, np;
    logic [31:0] prev;
    n_checks  = 0;
    n_errors  = 0;
    RSTB      = 1'b0;
    EN_MASK   = 4'hF;
    HOLD_REQ  = 4'h0;
    READY_OUT = 1'b1;
    clear_src();

    // Reset values
    #1;
    chk_out("reset", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0);
    repeat (2) @(posedge CLK);
    #2;
    RSTB = 1'b1;

    // Round-robin: all four channels requesting, bursts of two
    for (int i = 0; i < N; i++) rem[i] = 100;
    upd();
    for (int k = 0; k < 5; k++) begin
      c    = k % 4;
      n    = (k / 4) * 2;
      p    = (k + 3) % 4;
      np   = (k > 0) ? ((k - 1) / 4) * 2 : 0;
      prev = (k == 0) ? 32'h0 : d(p, np + 1);
      cyc(); chk_out("rr_arb",  4'(1 << c), 1'b0, prev,        2'(c), 1'b1);
      cyc(); chk_out("rr_pop",  4'(1 << c), 1'b1, d(c, n),     2'(c), 1'b1);
      cyc(); chk_out("rr_idle", 4'b0000,    1'b1, d(c, n + 1), 2'(c), 1'b0);
    end
    clear_src();
    cyc(); chk_out("rr_done", 4'b0000, 1'b0, d(0, 3), 2'd0, 1'b0);

    // Burst limit: channel 1 alone with five words -> 2, 2, 1
    rem[1] = 5;
    upd();
    cyc(); chk_out("bl_arb1",  4'b0010, 1'b0, d(0, 3), 2'd1, 1'b1);
    cyc(); chk_out("bl_w0",    4'b0010, 1'b1, d(1, 0), 2'd1, 1'b1);
    cyc(); chk_out("bl_w1",    4'b0000, 1'b1, d(1, 1), 2'd1, 1'b0);
    cyc(); chk_out("bl_arb2",  4'b0010, 1'b0, d(1, 1), 2'd1, 1'b1);
    cyc(); chk_out("bl_w2",    4'b0010, 1'b1, d(1, 2), 2'd1, 1'b1);
    cyc(); chk_out("bl_w3",    4'b0000, 1'b1, d(1, 3), 2'd1, 1'b0);
    cyc(); chk_out("bl_arb3",  4'b0010, 1'b0, d(1, 3), 2'd1, 1'b1);
    cyc(); chk_out("bl_w4",    4'b0000, 1'b1, d(1, 4), 2'd1, 1'b1);
    cyc(); chk_out("bl_done",  4'b0000, 1'b0, d(1, 4), 2'd1, 1'b0);

    // Preemption: channel 3 granted, channel 0 raises hold with 40 words
    rem[3] = 10;
    upd();
    cyc(); chk_out("pre_arb3", 4'b1000, 1'b0, d(1, 4), 2'd3, 1'b1);
    HOLD_REQ[0] = 1'b1;
    rem[0] = 40;
    upd();
    cyc(); chk_out("pre_rel3", 4'b0000, 1'b1, d(3, 0), 2'd3, 1'b0);
    cyc(); chk_out("pre_arb0", 4'b0001, 1'b0, d(3, 0), 2'd0, 1'b1);
    for (int j = 0; j < 40; j++) begin
      cyc(); chk_out("hold_w", (j < 39) ? 4'b0001 : 4'b0000, 1'b1, d(0, j), 2'd0, 1'b1);
    end
    repeat (3) begin
      cyc(); chk_out("hold_empty", 4'b0000, 1'b0, d(0, 39), 2'd0, 1'b1);
    end
    HOLD_REQ[0] = 1'b0;
    cyc(); chk_out("hold_drop", 4'b0000, 1'b0, d(0, 39), 2'd0, 1'b0);

    // Backpressure mid-burst on channel 3
    cyc(); chk_out("bp_arb3", 4'b1000, 1'b0, d(0, 39), 2'd3, 1'b1);
    cyc(); chk_out("bp_w1",   4'b1000, 1'b1, d(3, 1),  2'd3, 1'b1);
    READY_OUT = 1'b0;
    repeat (5) begin
      cyc(); chk_out("bp_stall", 4'b0000, 1'b0, d(3, 1), 2'd3, 1'b1);
    end
    READY_OUT = 1'b1;
    cyc(); chk_out("bp_resume", 4'b0000, 1'b1, d(3, 2), 2'd3, 1'b0);
    clear_src();
    cyc(); chk_out("bp_done",   4'b0000, 1'b0, d(3, 2), 2'd3, 1'b0);

    // Enable mask 1010, then channel 3 disabled during its grant
    EN_MASK = 4'b1010;
    for (int i = 0; i < N; i++) rem[i] = 100;
    upd();
    cyc(); chk_out("en_arb1", 4'b0010, 1'b0, d(3, 2), 2'd1, 1'b1);
    cyc(); chk_out("en_w0",   4'b0010, 1'b1, d(1, 0), 2'd1, 1'b1);
    cyc(); chk_out("en_w1",   4'b0000, 1'b1, d(1, 1), 2'd1, 1'b0);
    cyc(); chk_out("en_arb3", 4'b1000, 1'b0, d(1, 1), 2'd3, 1'b1);
    EN_MASK = 4'b0010;
    #1;
    chk("en_clear_rg", 32'(READ_GRANT), 32'h0);
    cyc(); chk_out("en_rel3", 4'b0000, 1'b0, d(1, 1), 2'd3, 1'b0);
    cyc(); chk_out("en_arb1b", 4'b0010, 1'b0, d(1, 1), 2'd1, 1'b1);
    clear_src();
    cyc(); chk_out("en_done", 4'b0000, 1'b0, d(1, 1), 2'd1, 1'b0);
    EN_MASK = 4'hF;

    // Asynchronous reset while channel 2 is popping
    rem[2] = 10;
    upd();
    cyc(); chk_out("rst_arb2", 4'b0100, 1'b0, d(1, 1), 2'd2, 1'b1);
    cyc(); chk_out("rst_w0",   4'b0100, 1'b1, d(2, 0), 2'd2, 1'b1);
    RSTB = 1'b0;
    #1;
    chk_out("rst_mid", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0);
    rem[1] = 5;
    cnt[1] = 0;
    upd();
    RSTB = 1'b1;
    cyc(); chk_out("post_rst_arb", 4'b0010, 1'b0, 32'h0,   2'd1, 1'b1);
    cyc(); chk_out("post_rst_w0",  4'b0010, 1'b1, d(1, 0), 2'd1, 1'b1);

    // Several holders: lowest index wins over round-robin order
    HOLD_REQ = 4'b1001;
    rem[0] = 2;
    cnt[0] = 0;
    rem[3] = 5;
    cnt[3] = 0;
    upd();
    cyc(); chk_out("mh_rel1", 4'b0000, 1'b1, d(1, 1), 2'd1, 1'b0);
    cyc(); chk_out("mh_arb0", 4'b0001, 1'b0, d(1, 1), 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
